// File: rtl/sram_ctrl_pkg.sv
// Shared types and width helpers for the SRAM word controller.
// The optional range checker is enabled with SRAM_CTRL_RANGE_CHECK_EN.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER, DONE} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;

    // Number of narrow SRAM beats needed to move one pipeline word.
    function automatic int beats_of(input int data_w, input int dq_w);
        return data_w / dq_w;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_dq_pad.sv
// Tri-state driver for the SRAM data bus plus the read-capture register
// that assembles narrow beats into the full load word.
module sram_dq_pad #(
    parameter int DATA_W    = 32,
    parameter int SRAM_DQ_W = 16,
    parameter int BEAT_W    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 oe,
    input  logic [SRAM_DQ_W-1:0] dout,
    input  logic                 cap_en,
    input  logic [BEAT_W-1:0]    cap_beat,
    output logic [DATA_W-1:0]    rd_data,
    inout  wire  [SRAM_DQ_W-1:0] sram_dq
);

    logic [DATA_W-1:0] rd_data_reg;

    assign sram_dq = oe ? dout : {SRAM_DQ_W{1'bz}};
    assign rd_data = rd_data_reg;

    // Capture the bus into the slice of the current beat on its final cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (cap_en) begin
            rd_data_reg[int'(cap_beat)*SRAM_DQ_W +: SRAM_DQ_W] <= sram_dq;
        end
    end

endmodule

// File: rtl/sram_word_ctrl.sv
// Word-wide request to multi-beat asynchronous SRAM sequencer.
// Define SRAM_CTRL_RANGE_CHECK_EN to add the err port and address range check.
module sram_word_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int          DATA_W          = 32,
    parameter int          SRAM_DQ_W       = 16,
    parameter int          SRAM_ADDR_W     = 18,
    parameter logic [31:0] BASE_ADDR       = 32'd1024,
    parameter int          WAIT_CYCLES     = 1,
    parameter int          RECOVERY_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   ready,
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    output logic                   err,
`endif
    inout  wire  [SRAM_DQ_W-1:0]   sram_dq,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n,
    output logic                   sram_we_n,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n
);

    localparam int BEATS   = beats_of(DATA_W, SRAM_DQ_W);
    localparam int ALIGN_W = $clog2(DATA_W / 8);
    localparam int BEAT_W  = cnt_w(BEATS);
    localparam int WAIT_W  = cnt_w(WAIT_CYCLES + 1);
    localparam int REC_W   = cnt_w(RECOVERY_CYCLES);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);
    localparam logic [REC_W-1:0]  REC_LAST  = REC_W'(RECOVERY_CYCLES - 1);

    state_t                 state_reg, state_next;
    op_t                    op_reg, op_next;
    logic [SRAM_ADDR_W-1:0] base_reg, base_next;
    logic [DATA_W-1:0]      wdata_reg, wdata_next;
    logic [BEAT_W-1:0]      beat_reg, beat_next;
    logic [WAIT_W-1:0]      wait_reg, wait_next;
    logic [REC_W-1:0]       rec_reg, rec_next;

    logic [SRAM_ADDR_W-1:0] sram_addr_reg;
    logic [SRAM_DQ_W-1:0]   dq_out_reg;
    logic                   dq_oe_reg;
    logic                   we_n_reg, ce_n_reg, oe_n_reg;
    logic                   err_reg;

    logic [31:0] word_full;
    logic        range_bad;
    logic        access_next;
    logic        wr_beat_next;
    logic        cap_en;

    assign word_full = (addr - BASE_ADDR) >> ALIGN_W;

`ifdef SRAM_CTRL_RANGE_CHECK_EN
    logic [63:0] lin_wide;
    assign lin_wide  = {32'd0, word_full} * 64'(BEATS);
    assign range_bad = (addr < BASE_ADDR)
                     || ((addr & 32'(DATA_W / 8 - 1)) != 32'd0)
                     || (lin_wide >= (64'd1 << SRAM_ADDR_W));
    assign err = err_reg;
`else
    assign range_bad = 1'b0;
`endif

    // Next-state and counter logic for the access sequencer.
    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        base_next  = base_reg;
        wdata_next = wdata_reg;
        beat_next  = beat_reg;
        wait_next  = wait_reg;
        rec_next   = rec_reg;
        unique case (state_reg)
            IDLE: begin
                if (rd_en || wr_en) begin
                    op_next    = wr_en ? OP_WR : OP_RD;
                    base_next  = SRAM_ADDR_W'(word_full * 32'(BEATS));
                    wdata_next = wr_data;
                    beat_next  = '0;
                    wait_next  = '0;
                    rec_next   = '0;
                    state_next = range_bad ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (wait_reg == WAIT_LAST) begin
                    wait_next = '0;
                    if (beat_reg == BEAT_LAST) begin
                        beat_next  = '0;
                        state_next = (RECOVERY_CYCLES == 0) ? DONE : RECOVER;
                    end else begin
                        beat_next = beat_reg + 1'b1;
                    end
                end else begin
                    wait_next = wait_reg + 1'b1;
                end
            end
            RECOVER: begin
                if (rec_reg == REC_LAST) begin
                    rec_next   = '0;
                    state_next = DONE;
                end else begin
                    rec_next = rec_reg + 1'b1;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign access_next  = (state_next == ACCESS);
    assign wr_beat_next = access_next && (op_next == OP_WR);

    // State, counters and strobes; strobes are computed from next state so
    // they are glitch-free registers aligned with the cycle they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            op_reg        <= OP_RD;
            base_reg      <= '0;
            wdata_reg     <= '0;
            beat_reg      <= '0;
            wait_reg      <= '0;
            rec_reg       <= '0;
            sram_addr_reg <= '0;
            dq_out_reg    <= '0;
            dq_oe_reg     <= 1'b0;
            we_n_reg      <= 1'b1;
            ce_n_reg      <= 1'b1;
            oe_n_reg      <= 1'b1;
            err_reg       <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            base_reg   <= base_next;
            wdata_reg  <= wdata_next;
            beat_reg   <= beat_next;
            wait_reg   <= wait_next;
            rec_reg    <= rec_next;
            ce_n_reg   <= !access_next;
            oe_n_reg   <= !(access_next && (op_next == OP_RD));
            we_n_reg   <= !(wr_beat_next && (wait_next != WAIT_LAST));
            dq_oe_reg  <= wr_beat_next;
            dq_out_reg <= wdata_next[int'(beat_next)*SRAM_DQ_W +: SRAM_DQ_W];
            err_reg    <= (state_reg == IDLE) && (rd_en || wr_en) && range_bad;
            if (access_next) begin
                sram_addr_reg <= base_next + SRAM_ADDR_W'(beat_next);
            end
        end
    end

    assign cap_en = (state_reg == ACCESS) && (op_reg == OP_RD) && (wait_reg == WAIT_LAST);

    sram_dq_pad #(
        .DATA_W    (DATA_W),
        .SRAM_DQ_W (SRAM_DQ_W),
        .BEAT_W    (BEAT_W)
    ) u_pad (
        .clk      (clk),
        .rst      (rst),
        .oe       (dq_oe_reg),
        .dout     (dq_out_reg),
        .cap_en   (cap_en),
        .cap_beat (beat_reg),
        .rd_data  (rd_data),
        .sram_dq  (sram_dq)
    );

    assign ready     = ((state_reg == IDLE) && !rd_en && !wr_en) || (state_reg == DONE);
    assign sram_addr = sram_addr_reg;
    assign sram_we_n = we_n_reg;
    assign sram_ce_n = ce_n_reg;
    assign sram_oe_n = oe_n_reg;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Bench for sram_word_ctrl: one default instance and one with
// WAIT_CYCLES=3 / RECOVERY_CYCLES=0, each on its own behavioural SRAM.
module tb_sram_word_ctrl;

    localparam int WC0 = 1, RC0 = 2;
    localparam int WC1 = 3, RC1 = 0;
    localparam int BEATS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd_en [2];
    logic        wr_en [2];
    logic [31:0] addr [2];
    logic [31:0] wr_data [2];
    logic [31:0] rd_data [2];
    logic        ready [2];
    logic [17:0] sram_addr [2];
    logic        ub_n [2];
    logic        lb_n [2];
    logic        we_n [2];
    logic        ce_n [2];
    logic        oe_n [2];
`ifdef SRAM_CTRL_RANGE_CHECK_EN
    logic        err [2];
`endif
    wire  [15:0] dq0;
    wire  [15:0] dq1;

    // Behavioural SRAM contents and the bench's own expectation of them.
    logic [15:0] mem [2][1024];
    logic [15:0] exp_mem [2][1024];
    logic [31:0] exp_rd [2];

    logic        pre_en;
    int          pre_i;
    int          pre_a;
    logic [15:0] pre_v;

    int tests = 0;
    int fails = 0;

    sram_word_ctrl #(.WAIT_CYCLES(WC0), .RECOVERY_CYCLES(RC0)) dut0 (
        .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]), .addr(addr[0]),
        .wr_data(wr_data[0]), .rd_data(rd_data[0]), .ready(ready[0]),
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        .err(err[0]),
`endif
        .sram_dq(dq0), .sram_addr(sram_addr[0]), .sram_ub_n(ub_n[0]), .sram_lb_n(lb_n[0]),
        .sram_we_n(we_n[0]), .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0])
    );

    sram_word_ctrl #(.WAIT_CYCLES(WC1), .RECOVERY_CYCLES(RC1)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]), .addr(addr[1]),
        .wr_data(wr_data[1]), .rd_data(rd_data[1]), .ready(ready[1]),
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        .err(err[1]),
`endif
        .sram_dq(dq1), .sram_addr(sram_addr[1]), .sram_ub_n(ub_n[1]), .sram_lb_n(lb_n[1]),
        .sram_we_n(we_n[1]), .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1])
    );

    // Asynchronous SRAM read: drive the bus while chip and output enables are low.
    assign dq0 = (!ce_n[0] && !oe_n[0]) ? mem[0][sram_addr[0][9:0]] : 16'bz;
    assign dq1 = (!ce_n[1] && !oe_n[1]) ? mem[1][sram_addr[1][9:0]] : 16'bz;

    // SRAM write while we_n is low, plus a back-door preload port.
    always @(posedge clk) begin
        if (!ce_n[0] && !we_n[0]) mem[0][sram_addr[0][9:0]] <= dq0;
        if (!ce_n[1] && !we_n[1]) mem[1][sram_addr[1][9:0]] <= dq1;
        if (pre_en) mem[pre_i][pre_a] <= pre_v;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int i, input int a, input logic [15:0] v);
        @(negedge clk);
        pre_en = 1'b1; pre_i = i; pre_a = a; pre_v = v;
        exp_mem[i][a] = v;
    endtask

    // One request held until ready; checks latency, strobe counts and data.
    task automatic run_txn(input int i, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] data, input bit drop, input bit bad);
        int wc, rc, exp_lat, cyc, we_low, ce_low, w;
        bit done;
        wc = (i == 0) ? WC0 : WC1;
        rc = (i == 0) ? RC0 : RC1;
        exp_lat = bad ? 1 : BEATS * (wc + 1) + rc + 1;
        w = bad ? 0 : int'((a - 32'd1024) >> 2);
        @(posedge clk); #1;
        addr[i] = a; wr_data[i] = data; rd_en[i] = rd; wr_en[i] = wr;
        cyc = 0; we_low = 0; ce_low = 0; done = 1'b0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            if (!we_n[i]) we_low++;
            if (!ce_n[i]) ce_low++;
            if (ready[i] === 1'b1) begin
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
                if (drop && cyc == 2) begin
                    rd_en[i] = 1'b0; wr_en[i] = 1'b0;
                end
            end
        end
        if (!bad) begin
            if (wr) begin
                exp_mem[i][2*w]   = data[15:0];
                exp_mem[i][2*w+1] = data[31:16];
            end else begin
                exp_rd[i] = {exp_mem[i][2*w+1], exp_mem[i][2*w]};
            end
        end
        $display("[TB] dut%0d %s addr=0x%0h data=0x%0h cycles=%0d rd_data=0x%0h",
                 i, wr ? "WR" : "RD", a, data, cyc, rd_data[i]);
        check_eq("latency", cyc, exp_lat);
        check_eq("rd_data", rd_data[i], exp_rd[i]);
        check_eq("we_low_cycles", we_low, (wr && !bad) ? BEATS * wc : 0);
        check_eq("ce_low_cycles", ce_low, bad ? 0 : BEATS * (wc + 1));
`ifdef SRAM_CTRL_RANGE_CHECK_EN
        check_eq("err", err[i], bad);
`endif
        @(posedge clk); #1;
        rd_en[i] = 1'b0; wr_en[i] = 1'b0;
        if (wr && !bad) begin
            check_eq("sram_word", {mem[i][2*w+1], mem[i][2*w]}, {exp_mem[i][2*w+1], exp_mem[i][2*w]});
        end
    endtask

    initial begin
        rst = 1'b1;
        pre_en = 1'b0; pre_i = 0; pre_a = 0; pre_v = '0;
        for (int i = 0; i < 2; i++) begin
            rd_en[i] = 1'b0; wr_en[i] = 1'b0; addr[i] = '0; wr_data[i] = '0;
            exp_rd[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_ready", ready[i], 1'b1);
            check_eq("rst_ce_n", ce_n[i], 1'b1);
            check_eq("rst_we_n", we_n[i], 1'b1);
            check_eq("rst_oe_n", oe_n[i], 1'b1);
            check_eq("rst_rd_data", rd_data[i], 32'h0);
            check_eq("rst_sram_addr", sram_addr[i], 32'h0);
            check_eq("ub_lb", {ub_n[i], lb_n[i]}, 2'b00);
        end
        rst = 1'b0;

        // Fill both SRAMs with known random contents.
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 256; k++)
                preload(i, k, 16'($urandom));
        preload(0, 4, 16'h5678);
        preload(0, 5, 16'h1234);
        @(negedge clk);
        pre_en = 1'b0;

        // Directed cases.
        run_txn(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, 1'b0);
        run_txn(0, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, 1'b0);
        run_txn(0, 1'b1, 1'b1, 32'd1024, 32'hA5A50F0F, 1'b0, 1'b0);
        run_txn(1, 1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 1'b0, 1'b0);
        run_txn(1, 1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, 1'b0);

        // Reset in cycle 3 of a write (word 200 is never read back).
        @(posedge clk); #1;
        addr[0] = 32'd1024 + 32'd800; wr_data[0] = 32'h13579BDF; wr_en[0] = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        check_eq("mid_rst_ce_n", ce_n[0], 1'b1);
        check_eq("mid_rst_we_n", we_n[0], 1'b1);
        check_eq("mid_rst_oe_n", oe_n[0], 1'b1);
        check_eq("mid_rst_dq_drive", dut0.u_pad.oe, 1'b0);
        check_eq("mid_rst_addr", sram_addr[0], 32'h0);
        check_eq("mid_rst_ready_held", ready[0], 1'b0);
        wr_en[0] = 1'b0;
        #1;
        check_eq("mid_rst_ready_idle", ready[0], 1'b1);
        @(negedge clk);
        rst = 1'b0;
        run_txn(0, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 1'b0);

        // Randomised traffic, including both-high requests and mid-access drops.
        for (int n = 0; n < 60; n++) begin
            int i, kind, w;
            i = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 3));
            w = int'($urandom_range(0, 127));
            run_txn(i, kind != 1, kind != 0, 32'd1024 + 32'(w * 4), $urandom,
                    $urandom_range(0, 3) == 0, 1'b0);
        end

`ifdef SRAM_CTRL_RANGE_CHECK_EN
        run_txn(0, 1'b1, 1'b0, 32'd1000, 32'h0, 1'b0, 1'b1);
        run_txn(0, 1'b1, 1'b0, 32'd1026, 32'h0, 1'b0, 1'b1);
        run_txn(1, 1'b0, 1'b1, 32'd525312, 32'h11112222, 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
